// File: rtl/muldiv_pkg.sv
// Shared encodings and defaults for the iterative multiply/divide sequencer.
package muldiv_pkg;

  localparam int WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Pipeline-facing port bundle of the multiply/divide unit (EX request, MF/MT traffic, HI/LO).
interface muldiv_if #(
  parameter int WIDTH = muldiv_pkg::WIDTH_DEFAULT
) ();

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             mf_req;
  logic             mt_hi;
  logic             mt_lo;
  logic [WIDTH-1:0] mt_val;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_val, rt_val, mf_req, mt_hi, mt_lo, mt_val,
    input  busy, stall, done, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, mf_req, mt_hi, mt_lo, mt_val,
    output busy, stall, done, hi, lo
  );

endinterface

// File: rtl/muldiv_step.sv
// One loop iteration: shift-add multiply step or restoring trial-subtract divide step.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic               is_div_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [2*WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0]   opb_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic [2*WIDTH-1:0] opa_o,
  output logic [WIDTH-1:0]   opb_o
);

  logic [WIDTH:0] trial_rem;
  logic [WIDTH:0] trial_diff;

  // Divide: acc holds the partial remainder, opa the divisor, opb the dividend shifting into
  // the remainder while quotient bits shift in behind it. A set top bit of the difference
  // means the subtraction borrowed and the remainder is restored.
  always_comb begin
    trial_rem  = {acc_i[WIDTH-1:0], opb_i[WIDTH-1]};
    trial_diff = trial_rem - {1'b0, opa_i[WIDTH-1:0]};
    acc_o      = acc_i;
    opa_o      = opa_i;
    opb_o      = opb_i;
    if (is_div_i) begin
      if (!trial_diff[WIDTH]) begin
        acc_o = {{WIDTH{1'b0}}, trial_diff[WIDTH-1:0]};
        opb_o = {opb_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = {{WIDTH{1'b0}}, trial_rem[WIDTH-1:0]};
        opb_o = {opb_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      // Multiply: multiplicand walks left, multiplier walks right, product accumulates in place.
      acc_o = opb_i[0] ? (acc_i + opa_i) : acc_i;
      opa_o = {opa_i[2*WIDTH-2:0], 1'b0};
      opb_o = {1'b0, opb_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer with HI/LO registers and pipeline stall generation.
// Optional: define MULDIV_EARLY_OUT_EN to end a multiply once the remaining multiplier bits are zero.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = 6
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  state_e             state_q;
  logic               busy_q;
  logic               done_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               is_div_q;
  logic               neg_res_q;
  logic               neg_rem_q;
  logic               div0_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] opa_q;
  logic [WIDTH-1:0]   opb_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic [2*WIDTH-1:0] acc_d;
  logic [2*WIDTH-1:0] opa_d;
  logic [WIDTH-1:0]   opb_d;
  logic [WIDTH-1:0]   hi_d;
  logic [WIDTH-1:0]   lo_d;
  logic               last_iter;
  logic               early_out;

  logic               start_div;
  logic               start_signed;
  logic [WIDTH-1:0]   rs_mag;
  logic [WIDTH-1:0]   rt_mag;

  assign start_div    = op_is_div(bus.op);
  assign start_signed = op_is_signed(bus.op);
  assign rs_mag       = (start_signed && bus.rs_val[WIDTH-1]) ? -bus.rs_val : bus.rs_val;
  assign rt_mag       = (start_signed && bus.rt_val[WIDTH-1]) ? -bus.rt_val : bus.rt_val;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (is_div_q),
    .acc_i    (acc_q),
    .opa_i    (opa_q),
    .opb_i    (opb_q),
    .acc_o    (acc_d),
    .opa_o    (opa_d),
    .opb_o    (opb_d)
  );

  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef MULDIV_EARLY_OUT_EN
  assign early_out = !is_div_q && (opb_d == '0);
`else
  assign early_out = 1'b0;
`endif

  // Sign fixup. Divide by zero leaves the quotient at all ones; the remainder still takes the
  // dividend sign, which restores the original rs_val from its magnitude.
  always_comb begin
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    prod = neg_res_q ? -acc_q : acc_q;
    quo  = div0_q ? '1 : (neg_res_q ? -opb_q : opb_q);
    rem  = neg_rem_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    hi_d = is_div_q ? rem : prod[2*WIDTH-1:WIDTH];
    lo_d = is_div_q ? quo : prod[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      acc_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q   <= RUN;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            is_div_q  <= start_div;
            neg_res_q <= start_signed && (bus.rs_val[WIDTH-1] ^ bus.rt_val[WIDTH-1]);
            neg_rem_q <= start_signed && start_div && bus.rs_val[WIDTH-1];
            div0_q    <= start_div && (bus.rt_val == '0);
            acc_q     <= '0;
            opa_q     <= {{WIDTH{1'b0}}, start_div ? rt_mag : rs_mag};
            opb_q     <= start_div ? rs_mag : rt_mag;
          end else begin
            if (bus.mt_hi) hi_q <= bus.mt_val;
            if (bus.mt_lo) lo_q <= bus.mt_val;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          opa_q <= opa_d;
          opb_q <= opb_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_iter || early_out) state_q <= FIX;
        end
        FIX: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.stall = busy_q & (bus.start | bus.mf_req | bus.mt_hi | bus.mt_lo);
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: latency, results, divide corner cases, stall and MF/MT traffic.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs [12] = '{
    '{OP_DIVU,  32'd100,        32'd7,          32'd2,          32'd14},
    '{OP_DIV,   32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   32'hFFFFFFFD},
    '{OP_DIV,   32'd7,          32'hFFFFFFFE,   32'd1,          32'hFFFFFFFD},
    '{OP_DIV,   32'h00001234,   32'd0,          32'h00001234,   32'hFFFFFFFF},
    '{OP_DIV,   32'hFFFFFFF9,   32'd0,          32'hFFFFFFF9,   32'hFFFFFFFF},
    '{OP_DIVU,  32'h80000000,   32'd0,          32'h80000000,   32'hFFFFFFFF},
    '{OP_DIV,   32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000},
    '{OP_DIVU,  32'hFFFFFFFF,   32'd2,          32'd1,          32'h7FFFFFFF},
    '{OP_MULTU, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE,   32'h00000001},
    '{OP_MULT,  32'h80000000,   32'h80000000,   32'h40000000,   32'h00000000},
    '{OP_MULT,  32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'hFFFFFFFF},
    '{OP_MULT,  32'hFFFFFFFC,   32'hFFFFFFFB,   32'd0,          32'd20}
  };

  // Launch one op and follow it to its done pulse (or a 40-edge limit); returns after the done edge.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int edges, output bit busy_e0, output bit held);
    logic [31:0] h0, l0;
    @(negedge clk);
    bus.op = op; bus.rs_val = a; bus.rt_val = b; bus.start = 1'b1;
    h0 = bus.hi; l0 = bus.lo;
    @(posedge clk); edges = 1; #1;
    busy_e0 = bus.busy; held = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    while (edges < 40) begin
      @(posedge clk); edges++; #1;
      if (bus.done) break;
      if (bus.hi !== h0 || bus.lo !== l0) held = 1'b0;
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    bus.start = 0; bus.op = 0; bus.rs_val = 0; bus.rt_val = 0;
    bus.mf_req = 1; bus.mt_hi = 0; bus.mt_lo = 0; bus.mt_val = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
    checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h want 0", bus.hi); end
    checks++; if (bus.lo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h want 0", bus.lo); end
    rst = 1'b0; bus.mf_req = 0;
  endtask

  task automatic test_mult();
    int edges; bit b0, held;
    run_op(OP_MULT, 32'd7, 32'hFFFFFFFD, edges, b0, held);
    checks++; if (edges !== 34) begin errors++; $display("FAIL mult_latency: got %0d want 34", edges); end
    checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL mult_busy_e0: got %b want 1", b0); end
    checks++; if (held !== 1'b1) begin errors++; $display("FAIL mult_hilo_hold: got %b want 1", held); end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL mult_done: got %b want 1", bus.done); end
    checks++; if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_lo: got %h want ffffffeb", bus.lo); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mult_busy_end: got %b want 0", bus.busy); end
    @(posedge clk); #1;
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse: got %b want 0", bus.done); end
  endtask

  task automatic test_vectors();
    int edges; bit b0, held;
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, edges, b0, held);
      checks++; if (edges !== 34) begin errors++; $display("FAIL vec%0d_latency: got %0d want 34", i, edges); end
      checks++; if (bus.hi !== vecs[i].hi) begin errors++; $display("FAIL vec%0d_hi: got %h want %h", i, bus.hi, vecs[i].hi); end
      checks++; if (bus.lo !== vecs[i].lo) begin errors++; $display("FAIL vec%0d_lo: got %h want %h", i, bus.lo, vecs[i].lo); end
    end
  endtask

  task automatic test_mf_stall();
    bit bad = 1'b0; bit seen = 1'b0;
    @(negedge clk); bus.op = OP_MULTU; bus.rs_val = 3; bus.rt_val = 4; bus.start = 1;
    @(posedge clk); @(negedge clk); bus.start = 0;
    repeat (2) @(negedge clk);
    bus.mf_req = 1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (bus.done) begin seen = 1'b1; break; end
      if (bus.stall !== 1'b1) bad = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL mf_done_timeout: got %b want 1", seen); end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL mf_stall_held: dropped=%b want 0", bad); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL mf_stall_release: got %b want 0", bus.stall); end
    checks++; if (bus.lo !== 32'd12) begin errors++; $display("FAIL mf_lo: got %h want 0000000c", bus.lo); end
    checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL mf_hi: got %h want 0", bus.hi); end
    bus.mf_req = 0;
  endtask

  task automatic test_mt();
    bit bad = 1'b0; bit seen = 1'b0;
    @(negedge clk); bus.mt_hi = 1; bus.mt_val = 32'hABCD; #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL mthi_idle_stall: got %b want 0", bus.stall); end
    @(posedge clk); #1;
    checks++; if (bus.hi !== 32'hABCD) begin errors++; $display("FAIL mthi_idle: got %h want 0000abcd", bus.hi); end
    @(negedge clk); bus.mt_hi = 0; bus.mt_lo = 1; bus.mt_val = 32'h1357;
    @(posedge clk); #1;
    checks++; if (bus.lo !== 32'h1357) begin errors++; $display("FAIL mtlo_idle: got %h want 00001357", bus.lo); end
    checks++; if (bus.hi !== 32'hABCD) begin errors++; $display("FAIL mtlo_hi_kept: got %h want 0000abcd", bus.hi); end
    @(negedge clk); bus.mt_lo = 0;
    bus.op = OP_MULTU; bus.rs_val = 2; bus.rt_val = 2; bus.start = 1;
    @(posedge clk); @(negedge clk);
    bus.start = 0; bus.mt_hi = 1; bus.mt_val = 32'h5555;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (bus.done) begin seen = 1'b1; break; end
      if (bus.stall !== 1'b1 || bus.hi !== 32'hABCD) bad = 1'b1;
      @(negedge clk);
    end
    checks++; if (bad !== 1'b0 || seen !== 1'b1) begin errors++; $display("FAIL mthi_busy_stall: bad=%b done=%b want 0/1", bad, seen); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL mthi_busy_release: got %b want 0", bus.stall); end
    checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL mthi_busy_result_hi: got %h want 0", bus.hi); end
    @(posedge clk); #1;
    checks++; if (bus.hi !== 32'h5555) begin errors++; $display("FAIL mthi_after_done: got %h want 00005555", bus.hi); end
    checks++; if (bus.lo !== 32'd4) begin errors++; $display("FAIL mthi_after_done_lo: got %h want 4", bus.lo); end
    @(negedge clk); bus.mt_hi = 0;
  endtask

  task automatic test_start_mt_collide();
    bit ok;
    @(negedge clk);
    bus.op = OP_MULTU; bus.rs_val = 5; bus.rt_val = 6; bus.start = 1;
    bus.mt_hi = 1; bus.mt_lo = 1; bus.mt_val = 32'h77;
    @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL collide_busy: got %b want 1", bus.busy); end
    checks++; if (bus.lo !== 32'd4) begin errors++; $display("FAIL collide_lo_dropped: got %h want 4", bus.lo); end
    checks++; if (bus.hi !== 32'h5555) begin errors++; $display("FAIL collide_hi_dropped: got %h want 00005555", bus.hi); end
    @(negedge clk); bus.start = 0; bus.mt_hi = 0; bus.mt_lo = 0;
    wait_done(ok);
    checks++; if (ok !== 1'b1 || bus.lo !== 32'd30) begin errors++; $display("FAIL collide_lo: got %h done=%b want 0000001e", bus.lo, ok); end
    checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL collide_hi: got %h want 0", bus.hi); end
  endtask

  task automatic test_back_to_back();
    bit bad = 1'b0; bit seen = 1'b0; bit ok;
    @(negedge clk); bus.op = OP_MULTU; bus.rs_val = 3; bus.rt_val = 5; bus.start = 1;
    @(posedge clk); @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      #1;
      if (bus.done) begin seen = 1'b1; break; end
      if (bus.stall !== 1'b1) bad = 1'b1;
      @(negedge clk);
    end
    checks++; if (bad !== 1'b0 || seen !== 1'b1) begin errors++; $display("FAIL b2b_stall_held: bad=%b done=%b want 0/1", bad, seen); end
    checks++; if (bus.busy !== 1'b0 || bus.stall !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: busy=%b stall=%b want 0/0", bus.busy, bus.stall); end
    checks++; if (bus.lo !== 32'd15) begin errors++; $display("FAIL b2b_first_lo: got %h want 0000000f", bus.lo); end
    bus.rs_val = 4;
    @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_restart: got %b want 1", bus.busy); end
    @(negedge clk); bus.start = 0;
    wait_done(ok);
    checks++; if (ok !== 1'b1 || bus.lo !== 32'd20) begin errors++; $display("FAIL b2b_second_lo: got %h done=%b want 00000014", bus.lo, ok); end
  endtask

  task automatic test_reset_mid();
    int edges; bit b0, held;
    @(negedge clk); bus.mt_hi = 1; bus.mt_val = 32'h99;
    @(negedge clk); bus.mt_hi = 0;
    bus.op = OP_MULTU; bus.rs_val = 32'h10; bus.rt_val = 32'h10; bus.start = 1;
    @(posedge clk); @(negedge clk); bus.start = 0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1; #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b want 0", bus.done); end
    checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL rstmid_hi: got %h want 0", bus.hi); end
    checks++; if (bus.lo !== 32'd0) begin errors++; $display("FAIL rstmid_lo: got %h want 0", bus.lo); end
    @(negedge clk); rst = 1'b0;
    run_op(OP_MULTU, 32'd2, 32'd3, edges, b0, held);
    checks++; if (edges !== 34) begin errors++; $display("FAIL rstmid_latency: got %0d want 34", edges); end
    checks++; if (bus.lo !== 32'd6) begin errors++; $display("FAIL rstmid_lo_after: got %h want 6", bus.lo); end
    checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL rstmid_hi_after: got %h want 0", bus.hi); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_vectors();
    test_mf_stall();
    test_mt();
    test_start_mt_collide();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
